// File: rtl/ysyx_23060203_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_23060203_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        OUT  = 2'd3
    } ifu_state_e;

    // Instruction payload handed to the decoder
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            fault;
    } fetch_t;

endpackage

// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: takes one pc at a time, reads the word over AXI-lite
// and hands pc/instruction/fault to the decoder; flush discards the pending fetch.
module ysyx_23060203_ifu
    import ysyx_23060203_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic        flush,

    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,

    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault
);

    ifu_state_e state;
    ifu_state_e state_nxt;
    logic       drop;
    logic       drop_nxt;
    logic       accept;
    logic       misaligned;
    logic       rsp_keep;
    fetch_t     out_q;

    assign accept     = in_valid & in_ready;
    assign misaligned = (in_pc[1:0] != 2'b00);
    // A response is kept only if no flush has hit this fetch, including this cycle
    assign rsp_keep   = (state == R) & rvalid & ~drop & ~flush;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
        end
    end

    // Next-state logic; a flush in AR/R only marks the fetch, the bus transfer still completes
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        case (state)
            IDLE: begin
                if (accept) state_nxt = misaligned ? OUT : AR;
            end
            AR: begin
                if (flush)   drop_nxt  = 1'b1;
                if (arready) state_nxt = R;
            end
            R: begin
                if (flush) drop_nxt = 1'b1;
                if (rvalid) begin
                    state_nxt = rsp_keep ? OUT : IDLE;
                    drop_nxt  = 1'b0;
                end
            end
            OUT: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    if (accept) state_nxt = misaligned ? OUT : AR;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        in_ready  = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: in_ready = ~flush;
            AR:   arvalid  = 1'b1;
            R:    rready   = 1'b1;
            OUT: begin
                out_valid = ~flush;
                in_ready  = ~flush & out_ready;
            end
            default: ;
        endcase
    end

    // Address and delivered-instruction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            araddr <= '0;
            out_q  <= '0;
        end else begin
            if (accept) begin
                out_q.pc <= in_pc;
                if (misaligned) begin
                    out_q.inst  <= '0;
                    out_q.fault <= 1'b1;
                end else begin
                    araddr <= in_pc;
                end
            end
            if (rsp_keep) begin
                out_q.inst  <= rdata;
                out_q.fault <= (rresp != RESP_OKAY);
            end
        end
    end

    assign out_pc    = out_q.pc;
    assign out_inst  = out_q.inst;
    assign out_fault = out_q.fault;

endmodule

// File: doc/ysyx_23060203_ifu.md
YSYX_23060203_IFU -- requirements
Module: ysyx_23060203_IFU

Interface
REQ-001 The block SHALL have no parameters; address and data widths are fixed at 32 bits.
REQ-002 The block SHALL have port clk  in  1  the single clock; all state updates on posedge.
REQ-003 The block SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  in  1  fetch address from the PC stage is valid.
REQ-005 The block SHALL have port in_ready  out  1  IFU accepts in_pc this cycle.
REQ-006 The block SHALL have port in_pc  in  32  address to fetch.
REQ-007 The block SHALL have port flush  in  1  redirect: discard any pending or held fetch.
REQ-008 The block SHALL have ports araddr out 32, arvalid out 1, arready in 1: AXI-lite read-address channel.
REQ-009 The block SHALL have ports rdata in 32, rresp in 2, rvalid in 1, rready out 1: AXI-lite read-data channel.
REQ-010 The block SHALL have ports out_valid out 1, out_ready in 1, out_pc out 32, out_inst out 32, out_fault out 1: fetched instruction to the decoder.

Function
REQ-011 FSM states SHALL be IDLE, AR, R, OUT.
REQ-012 in_ready SHALL be 1 iff !flush and (state==IDLE or (state==OUT and out_ready)).
REQ-013 On accept (in_valid & in_ready), pc SHALL be latched; pc[1:0]!=0 -> OUT with out_fault=1, out_inst=0, no bus access; else -> AR.
REQ-014 AR: arvalid=1, araddr=latched pc, both registered and stable until arready; arvalid&arready -> R next cycle.
REQ-015 R: rready=1; on rvalid, capture rdata into out_inst, out_fault=(rresp!=2'b00), -> OUT (or IDLE if drop set).
REQ-016 rvalid while in IDLE/AR/OUT SHALL be ignored (rready=0).
REQ-017 OUT: out_valid=!flush; on out_valid&out_ready -> IDLE, or directly -> AR/OUT if a new pc is accepted the same cycle (back-to-back).
REQ-018 out_pc/out_inst/out_fault SHALL be stable while out_valid & !out_ready.
REQ-019 Minimum latency: pc accepted at cycle N, arvalid at N+1; with arready at N+1 and rvalid at N+2, out_valid at N+3.
REQ-020 flush in IDLE: no accept that cycle. flush in OUT: held instruction discarded, -> IDLE, no out handshake.
REQ-021 flush in AR or R: set drop; the AXI transaction SHALL complete normally (arvalid not withdrawn); response discarded; -> IDLE; drop cleared.
REQ-022 flush during drop: no additional effect. flush and rvalid same cycle in R: response discarded.
REQ-023 Exactly one out_valid handshake SHALL occur per accepted non-dropped pc, in acceptance order.

Reset
REQ-024 rst asserted SHALL immediately force state=IDLE, arvalid=0, rready=0, out_valid=0, drop=0, araddr=0, out_pc=0, out_inst=0, out_fault=0.
REQ-025 Reset mid-transaction SHALL abandon the bus transaction; no response is awaited after release.
REQ-026 First accept SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-027 Shared package ysyx_23060203_pkg SHALL hold the IFU state enum and AXI response constant RESP_OKAY=2'b00.
REQ-028 The block SHALL be a single module with no sub-modules; one FSM plus data registers.

Verification
REQ-029 pc=0x80000000, arready=1 immediately, rvalid next cycle rdata=0x00000413 rresp=0 -> out_valid 3 cycles after accept, out_pc=0x80000000, out_inst=0x00000413, out_fault=0.
REQ-030 arready delayed 5 cycles, out_ready low 4 cycles -> araddr/arvalid and outputs stable throughout, single delivery.
REQ-031 pc=0x80000002 -> no arvalid, out_fault=1, out_inst=0, out_pc=0x80000002.
REQ-032 flush during AR, then rvalid with rdata=0xDEADBEEF -> arvalid held until arready, response consumed, no out_valid; next pc 0x80000100 fetched normally.
REQ-033 rresp=2'b10 -> out_fault=1, out_inst=rdata.
REQ-034 rst pulsed while in R -> all outputs zero immediately, in_ready=1 after release.
